// File: rtl/operand_regfile_pkg.sv
// Shared types for the operand register file, ALU wrapper and branch logic.
package regfile_pkg;

  localparam int PW   = 3;
  localparam int W    = 8;
  localparam int NREG = 2 ** PW;

  typedef logic [W-1:0]  word_t;
  typedef logic [PW-1:0] rptr_t;

  typedef struct packed {
    logic sc;
    logic cnd;
    logic zero;
    logic pari;
  } flags_t;

endpackage

// File: rtl/operand_regfile_if.sv
// Bus between the issue/control side (master) and the operand register file (slave).
interface operand_regfile_if;
  import regfile_pkg::*;

  logic  wr_en;
  rptr_t wr_addr;
  word_t dat_in;
  rptr_t rd_addr_a;
  rptr_t rd_addr_b;
  word_t dat_out_a;
  word_t dat_out_b;
  logic  flag_we;
  logic  sc_clr;
  logic  sc_in;
  logic  cnd_in;
  logic  zero_in;
  logic  pari_in;
  logic  sc_q;
  logic  cnd_q;
  logic  zero_q;
  logic  pari_q;

  modport master (
    output wr_en, wr_addr, dat_in, rd_addr_a, rd_addr_b,
    output flag_we, sc_clr, sc_in, cnd_in, zero_in, pari_in,
    input  dat_out_a, dat_out_b, sc_q, cnd_q, zero_q, pari_q
  );

  modport slave (
    input  wr_en, wr_addr, dat_in, rd_addr_a, rd_addr_b,
    input  flag_we, sc_clr, sc_in, cnd_in, zero_in, pari_in,
    output dat_out_a, dat_out_b, sc_q, cnd_q, zero_q, pari_q
  );

endinterface

// File: rtl/operand_regfile_status_reg.sv
// ALU status flags: captured together on flag_we, with a dedicated clear
// for the shift carry that overrides capture of that one bit.
module status_reg
  import regfile_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flag_we_i,
  input  logic   sc_clr_i,
  input  flags_t flags_i,
  output flags_t flags_o
);

  flags_t flags_q;
  flags_t flags_d;

  // Next flag state: capture or hold, then sc_clr overrides the carry bit only.
  always_comb begin
    flags_d = flags_q;
    if (flag_we_i) begin
      flags_d = flags_i;
    end else begin
      flags_d = flags_q;
    end
    if (sc_clr_i) begin
      flags_d.sc = 1'b0;
    end else if (flag_we_i) begin
      flags_d.sc = flags_i.sc;
    end else begin
      flags_d.sc = flags_q.sc;
    end
  end

  // Flag register; no bypass so a carry consumer always sees the prior capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/operand_regfile.sv
// Operand register file: flip-flop array with two combinational read ports
// (write-through bypass) plus the ALU status flag register.
module operand_regfile
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  operand_regfile_if.slave   rf
);

  word_t  mem_q [NREG];
  word_t  mem_d [NREG];
  flags_t flags_in_s;
  flags_t flags_s;

  // Next array state: only the addressed register takes dat_in on a write.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (rf.wr_en && (rf.wr_addr == rptr_t'(i))) begin
        mem_d[i] = rf.dat_in;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Register array; a write coincident with reset is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port A with write-through bypass so a result is usable the same cycle.
  always_comb begin
    if (rf.wr_en && (rf.rd_addr_a == rf.wr_addr)) begin
      rf.dat_out_a = rf.dat_in;
    end else begin
      rf.dat_out_a = mem_q[rf.rd_addr_a];
    end
  end

  // Read port B, bypassed independently of port A.
  always_comb begin
    if (rf.wr_en && (rf.rd_addr_b == rf.wr_addr)) begin
      rf.dat_out_b = rf.dat_in;
    end else begin
      rf.dat_out_b = mem_q[rf.rd_addr_b];
    end
  end

  assign flags_in_s = '{sc: rf.sc_in, cnd: rf.cnd_in, zero: rf.zero_in, pari: rf.pari_in};

  status_reg u_status_reg (
    .clk       (clk),
    .reset     (reset),
    .flag_we_i (rf.flag_we),
    .sc_clr_i  (rf.sc_clr),
    .flags_i   (flags_in_s),
    .flags_o   (flags_s)
  );

  assign rf.sc_q   = flags_s.sc;
  assign rf.cnd_q  = flags_s.cnd;
  assign rf.zero_q = flags_s.zero;
  assign rf.pari_q = flags_s.pari;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile: vector table plus hand-written
// reset, bypass, carry-chain and hold sequences.
module tb_operand_regfile;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] exp_mem [8];

  operand_regfile_if bus ();

  operand_regfile dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] d;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       fw;
    logic       clr;
    logic [3:0] fin;   // {sc, cnd, zero, pari}
    logic [7:0] ea;    // expected read A before the edge
    logic [7:0] eb;    // expected read B before the edge
    logic [3:0] ef;    // expected flags after the edge
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.sc_q, bus.cnd_q, bus.zero_q, bus.pari_q};
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.dat_in = 8'h00;
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0;
    bus.flag_we = 1'b0; bus.sc_clr = 1'b0;
    bus.sc_in = 1'b0; bus.cnd_in = 1'b0; bus.zero_in = 1'b0; bus.pari_in = 1'b0;

    // ---------------- reset state ----------------
    #1 reset = 1'b1;
    #1;
    check("reset_flags", 32'(flags_now()), 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(7 - i);
      #1;
      check($sformatf("reset_rd_a%0d", i), 32'(bus.dat_out_a), 32'h0);
      check($sformatf("reset_rd_b%0d", i), 32'(bus.dat_out_b), 32'h0);
    end
    for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
    edge_step();
    reset = 1'b0;

    // ---------------- vector table ----------------
    vecs[0]  = '{1'b1, 3'd0, 8'h10, 3'd0, 3'd1, 1'b1, 1'b0, 4'b1010, 8'h10, 8'h00, 4'b1010};
    vecs[1]  = '{1'b1, 3'd1, 8'h11, 3'd0, 3'd1, 1'b0, 1'b0, 4'b0000, 8'h10, 8'h11, 4'b1010};
    vecs[2]  = '{1'b1, 3'd2, 8'h12, 3'd2, 3'd3, 1'b1, 1'b0, 4'b0101, 8'h12, 8'h00, 4'b0101};
    vecs[3]  = '{1'b1, 3'd3, 8'h13, 3'd1, 3'd3, 1'b0, 1'b1, 4'b1111, 8'h11, 8'h13, 4'b0101};
    vecs[4]  = '{1'b1, 3'd4, 8'h14, 3'd4, 3'd4, 1'b1, 1'b1, 4'b1111, 8'h14, 8'h14, 4'b0111};
    vecs[5]  = '{1'b1, 3'd5, 8'h15, 3'd0, 3'd5, 1'b0, 1'b0, 4'b1000, 8'h10, 8'h15, 4'b0111};
    vecs[6]  = '{1'b1, 3'd6, 8'h16, 3'd6, 3'd2, 1'b1, 1'b0, 4'b1000, 8'h16, 8'h12, 4'b1000};
    vecs[7]  = '{1'b1, 3'd7, 8'h17, 3'd7, 3'd6, 1'b0, 1'b1, 4'b1111, 8'h17, 8'h16, 4'b0000};
    vecs[8]  = '{1'b0, 3'd0, 8'hFF, 3'd0, 3'd7, 1'b0, 1'b0, 4'b1111, 8'h10, 8'h17, 4'b0000};
    vecs[9]  = '{1'b0, 3'd4, 8'hEE, 3'd4, 3'd4, 1'b0, 1'b0, 4'b0000, 8'h14, 8'h14, 4'b0000};
    vecs[10] = '{1'b0, 3'd3, 8'hAA, 3'd3, 3'd3, 1'b1, 1'b0, 4'b1111, 8'h13, 8'h13, 4'b1111};

    for (int v = 0; v < 11; v++) begin
      bus.wr_en = vecs[v].we; bus.wr_addr = vecs[v].wa; bus.dat_in = vecs[v].d;
      bus.rd_addr_a = vecs[v].ra; bus.rd_addr_b = vecs[v].rb;
      bus.flag_we = vecs[v].fw; bus.sc_clr = vecs[v].clr;
      {bus.sc_in, bus.cnd_in, bus.zero_in, bus.pari_in} = vecs[v].fin;
      #1;
      check($sformatf("vec%0d_rd_a", v), 32'(bus.dat_out_a), 32'(vecs[v].ea));
      check($sformatf("vec%0d_rd_b", v), 32'(bus.dat_out_b), 32'(vecs[v].eb));
      if (vecs[v].we) exp_mem[vecs[v].wa] = vecs[v].d;
      edge_step();
      check($sformatf("vec%0d_flags", v), 32'(flags_now()), 32'(vecs[v].ef));
    end
    bus.flag_we = 1'b0; bus.sc_clr = 1'b0;

    // ---------------- bypass ----------------
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.dat_in = 8'h11;
    edge_step();
    exp_mem[2] = 8'h11;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.dat_in = 8'h3C;
    bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd2;
    #1;
    check("bypass_a", 32'(bus.dat_out_a), 32'h3C);
    check("bypass_b", 32'(bus.dat_out_b), 32'h3C);
    edge_step();
    exp_mem[2] = 8'h3C;
    bus.wr_en = 1'b0; bus.dat_in = 8'h00;
    #1;
    check("after_bypass_a", 32'(bus.dat_out_a), 32'h3C);
    check("after_bypass_b", 32'(bus.dat_out_b), 32'h3C);

    // ---------------- carry chain ----------------
    bus.flag_we = 1'b1;
    {bus.sc_in, bus.cnd_in, bus.zero_in, bus.pari_in} = 4'b1000;
    edge_step();
    check("carry_k", 32'(bus.sc_q), 32'h1);
    bus.sc_in = 1'b0;
    #1;
    check("carry_no_bypass", 32'(bus.sc_q), 32'h1);
    edge_step();
    check("carry_k1", 32'(bus.sc_q), 32'h0);

    // ---------------- hold ----------------
    {bus.sc_in, bus.cnd_in, bus.zero_in, bus.pari_in} = 4'b1111;
    edge_step();
    check("hold_set", 32'(flags_now()), 32'hF);
    bus.flag_we = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.sc_in   = 1'($urandom_range(1, 0));
      bus.cnd_in  = 1'($urandom_range(1, 0));
      bus.wr_addr = 3'($urandom_range(7, 0));
      bus.dat_in  = 8'($urandom_range(255, 0));
      edge_step();
      check($sformatf("hold_flags%0d", c), 32'(flags_now()), 32'hF);
    end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(i);
      #1;
      check($sformatf("hold_mem_a%0d", i), 32'(bus.dat_out_a), 32'(exp_mem[i]));
      check($sformatf("hold_mem_b%0d", i), 32'(bus.dat_out_b), 32'(exp_mem[i]));
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    edge_step();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.dat_in = 8'hA5;
    edge_step();
    bus.wr_en = 1'b0; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd3;
    #1;
    check("pre_reset_r3", 32'(bus.dat_out_a), 32'hA5);
    reset = 1'b1;
    #1;
    check("reset_r3", 32'(bus.dat_out_a), 32'h00);
    check("reset_flags_mid", 32'(flags_now()), 32'h0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.dat_in = 8'h5A;
    bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd3;
    #1;
    check("reset_bypass_a", 32'(bus.dat_out_a), 32'h5A);
    check("reset_bypass_b", 32'(bus.dat_out_b), 32'h00);
    edge_step();
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd0;
    #1;
    check("reset_write_lost", 32'(bus.dat_out_a), 32'h00);
    check("reset_r0", 32'(bus.dat_out_b), 32'h00);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.dat_in = 8'h77;
    edge_step();
    bus.wr_en = 1'b0; bus.rd_addr_a = 3'd1;
    #1;
    check("post_release_write", 32'(bus.dat_out_a), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
